// File: rtl/rcv_frame_ctrl.sv
// rcv_frame_ctrl
// Receive-side framing controller for the UART-style serial peripheral.
// Synchronises the raw line and finds the start bit. Times the bit centres and
// pulses shift_strobe into an external LSB-first shift register. When the
// frame is complete it checks the stop bit, latches the data word and keeps the
// status flags that the APB side reads.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge on the synchronised input
// START | half-bit wait; confirm the start bit is still low at its centre
// BITS  | full-bit timer; strobe the shift register at every bit centre
// CHECK | one cycle; sr_data holds stop+data, update rx_data and the flags
module rcv_frame_ctrl #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic [NUM_BITS:0]   sr_data,
    output logic                shift_strobe,
    input  logic                data_read,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                overrun_error,
    output logic                framing_error,
    output logic                rcv_busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(NUM_BITS + 2);

    localparam logic [TW-1:0] HALF_TC  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_TC   = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BITS  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t         state, next_state;
    logic [TW-1:0]  timer, timer_nxt;
    logic [CW-1:0]  bit_cnt, bit_cnt_nxt;
    logic           s1, s2, s3;
    logic           fall;
    logic           strobe;

    // Two-flop synchroniser plus one history flop for edge detection; idle is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= serial_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;

    // State, bit timer and bit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Next-state, timer and strobe decode.
    always_comb begin
        next_state  = state;
        timer_nxt   = timer;
        bit_cnt_nxt = bit_cnt;
        strobe      = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt   = '0;
                bit_cnt_nxt = '0;
                if (fall) begin
                    next_state = START;
                end
            end
            START: begin
                if (timer == HALF_TC) begin
                    timer_nxt = '0;
                    // A line back high at the start-bit centre was only a glitch.
                    next_state = s2 ? IDLE : BITS;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            BITS: begin
                if (timer == BIT_TC) begin
                    timer_nxt   = '0;
                    strobe      = 1'b1;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    // Data bits plus the stop bit have been shifted in.
                    if (bit_cnt == LAST_BIT) begin
                        next_state = CHECK;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            CHECK: begin
                timer_nxt   = '0;
                bit_cnt_nxt = '0;
                next_state  = IDLE;
            end
            default: begin
                timer_nxt   = '0;
                bit_cnt_nxt = '0;
                next_state  = IDLE;
            end
        endcase
    end

    assign shift_strobe = strobe;
    assign rcv_busy     = (state != IDLE);

    // Received word and status flags; a good frame load takes priority over a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else if (state == CHECK) begin
            if (sr_data[NUM_BITS]) begin
                rx_data       <= sr_data[NUM_BITS-1:0];
                data_ready    <= 1'b1;
                framing_error <= 1'b0;
                if (data_ready && !data_read) begin
                    overrun_error <= 1'b1;
                end else if (data_read) begin
                    overrun_error <= 1'b0;
                end
            end else begin
                framing_error <= 1'b1;
                // Bad frame loads nothing, so a read in this cycle still consumes the word.
                if (data_read) begin
                    data_ready    <= 1'b0;
                    overrun_error <= 1'b0;
                end
            end
        end else if (data_read) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rcv_frame_ctrl.sv
// Bench for rcv_frame_ctrl with a behavioural LSB-first shift register attached.
module tb_rcv_frame_ctrl;

    localparam int NB  = 8;
    localparam int CPB = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          n_rst;
    logic          serial_in;
    logic [NB:0]   sr_data;
    logic          shift_strobe;
    logic          data_read;
    logic [NB-1:0] rx_data;
    logic          data_ready;
    logic          overrun_error;
    logic          framing_error;
    logic          rcv_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int        t;
        logic [7:0] rx;
        logic      dr;
        logic      ov;
        logic      fe;
    } st_t;

    int  str_q[$];
    st_t st_q[$];

    logic [7:0] m_rx;
    logic       m_dr, m_ov, m_fe;
    logic       prev_busy = 1'b0;

    rcv_frame_ctrl #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .sr_data      (sr_data),
        .shift_strobe (shift_strobe),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .overrun_error(overrun_error),
        .framing_error(framing_error),
        .rcv_busy     (rcv_busy)
    );

    assign n_rst = ~rst;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for flex_stp_sr(NUM_BITS+1, SHIFT_MSB=0): new bit enters at the top.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) sr_data <= '1;
        else if (shift_strobe) sr_data <= {serial_in, sr_data[NB:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard consumer: strobes and end-of-frame status as the DUT produces them.
    always @(negedge clk) begin
        if (!rst) begin
            if (shift_strobe) begin
                if (str_q.size() > 0) chk("strobe_cycle", cyc, str_q.pop_front());
                else chk("strobe_unexpected", 1, 0);
            end
            if (prev_busy && !rcv_busy) begin
                if (st_q.size() > 0) begin
                    st_t e;
                    e = st_q.pop_front();
                    chk("idle_cycle", cyc, e.t);
                    chk("rx_data", rx_data, e.rx);
                    chk("data_ready", data_ready, e.dr);
                    chk("overrun_error", overrun_error, e.ov);
                    chk("framing_error", framing_error, e.fe);
                end else begin
                    chk("idle_unexpected", 1, 0);
                end
            end
        end
        prev_busy = rcv_busy;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_strobe"}, shift_strobe, 0);
        chk({tag, "_busy"}, rcv_busy, 0);
        chk({tag, "_rx"}, rx_data, 0);
        chk({tag, "_dr"}, data_ready, 0);
        chk({tag, "_ov"}, overrun_error, 0);
        chk({tag, "_fe"}, framing_error, 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rx"}, rx_data, m_rx);
        chk({tag, "_dr"}, data_ready, m_dr);
        chk({tag, "_ov"}, overrun_error, m_ov);
        chk({tag, "_fe"}, framing_error, m_fe);
    endtask

    // Drives one frame; dr_chk pulses data_read in the CHECK cycle; abort_at>0 resets at that strobe.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic dr_chk,
                              input int abort_at);
        int  n0;
        st_t e;
        @(posedge clk); #1;
        n0 = cyc;
        for (int k = 1; k <= NB + 1; k++)
            if (abort_at == 0 || k < abort_at) str_q.push_back(n0 + 7 + CPB * k);
        if (abort_at == 0) begin
            if (stop) begin
                if (m_dr && !dr_chk) m_ov = 1'b1;
                else if (dr_chk) m_ov = 1'b0;
                m_rx = d;
                m_dr = 1'b1;
                m_fe = 1'b0;
            end else begin
                m_fe = 1'b1;
                if (dr_chk) begin
                    m_dr = 1'b0;
                    m_ov = 1'b0;
                end
            end
            e.t = n0 + 99; e.rx = m_rx; e.dr = m_dr; e.ov = m_ov; e.fe = m_fe;
            st_q.push_back(e);
        end
        for (int c = 0; c < 110; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c < 10) serial_in = 1'b0;
            else if (c < 90) serial_in = d[(c - 10) / 10];
            else if (c < 100) serial_in = stop;
            else serial_in = 1'b1;
            data_read = dr_chk && (c == 98);
            if (abort_at != 0 && c == 7 + CPB * abort_at) begin
                chk("strobe_before_rst", shift_strobe, 1);
                rst = 1'b1;
                #1;
                check_all_zero("async_rst");
                serial_in = 1'b1;
                data_read = 1'b0;
                str_q.delete();
                st_q.delete();
                m_rx = '0; m_dr = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
                repeat (3) @(posedge clk);
                #2 rst = 1'b0;
                break;
            end
        end
        data_read = 1'b0;
    endtask

    task automatic read_pulse();
        @(posedge clk); #1;
        data_read = 1'b1;
        @(posedge clk); #1;
        data_read = 1'b0;
        m_dr = 1'b0;
        m_ov = 1'b0;
    endtask

    initial begin
        st_t e;
        int  n0;
        rst = 1'b1;
        serial_in = 1'b1;
        data_read = 1'b0;
        m_rx = '0; m_dr = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_rst");
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("after_rst");

        // Short low pulse: START aborts with no strobe and no flag change.
        @(posedge clk); #1;
        n0 = cyc;
        e.t = n0 + 8; e.rx = m_rx; e.dr = m_dr; e.ov = m_ov; e.fe = m_fe;
        st_q.push_back(e);
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_busy", rcv_busy, 0);

        // Bad stop bit, then a good frame clears the framing error.
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        check_model("bad_frame");
        send_frame(8'h11, 1'b1, 1'b0, 0);
        check_model("good_11");
        read_pulse();
        check_model("read_11");
        read_pulse();
        check_model("read_when_empty");

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check_model("good_a5");
        read_pulse();

        // Two frames with no read -> overrun.
        send_frame(8'h01, 1'b1, 1'b0, 0);
        send_frame(8'h02, 1'b1, 1'b0, 0);
        check_model("overrun");
        chk("overrun_set", overrun_error, 1);
        read_pulse();
        check_model("overrun_read");

        // Read coincident with a good CHECK: load wins, no overrun.
        send_frame(8'h55, 1'b1, 1'b0, 0);
        send_frame(8'h7E, 1'b1, 1'b1, 0);
        check_model("read_at_check");

        // Reset at the 4th strobe, then a clean frame.
        send_frame(8'h99, 1'b1, 1'b0, 4);
        repeat (10) @(posedge clk);
        #1;
        check_all_zero("post_abort");
        send_frame(8'hC3, 1'b1, 1'b0, 0);
        check_model("after_abort_c3");

        repeat (5) @(posedge clk);
        #1;
        chk("strobes_left", str_q.size(), 0);
        chk("status_left", st_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
